// File: rtl/seq_gen_serial_if.sv
// Handshake and serial-stream bundle for seq_gen_serial.
// The master side requests transfers; the slave side (the generator) drives the stream.
interface seq_gen_serial_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern_in;
  logic [CNT_W-1:0] rpt_in;
  logic [CNT_W-1:0] gap_in;
  logic             x_out;
  logic             x_valid;
  logic             last_bit;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern_in, rpt_in, gap_in,
    input  x_out, x_valid, last_bit, busy, done
  );

  modport slave (
    input  start, abort, pattern_in, rpt_in, gap_in,
    output x_out, x_valid, last_bit, busy, done
  );
endinterface

// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter: emits a latched pattern MSB-first, rpt times,
// with an optional filler gap between repetitions. All outputs are registered.
module seq_gen_serial #(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 8,
  parameter logic GAP_FILL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  seq_gen_serial_if.slave  bus
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             x_out_q, x_out_d;
  logic             x_valid_q, x_valid_d;
  logic             last_bit_q, last_bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state logic; the state names what the registered outputs show in the following cycle.
  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    rem_d      = rem_q;
    gap_d      = gap_q;
    gcnt_d     = gcnt_q;
    idx_d      = idx_q;
    x_out_d    = 1'b0;
    x_valid_d  = 1'b0;
    last_bit_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          pat_d = bus.pattern_in;
          rem_d = bus.rpt_in;
          gap_d = bus.gap_in;
          if (bus.rpt_in != '0) begin
            state_d   = S_SEND;
            idx_d     = IDX_MSB;
            x_out_d   = bus.pattern_in[PAT_W-1];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SEND: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (idx_q != '0) begin
          idx_d      = idx_q - IDX_ONE;
          x_out_d    = pat_q[idx_d];
          x_valid_d  = 1'b1;
          last_bit_d = (idx_d == '0);
          busy_d     = 1'b1;
        end else begin
          // The LSB is on the wire now: this instance is complete.
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (gap_q == '0) begin
            state_d   = S_SEND;
            idx_d     = IDX_MSB;
            x_out_d   = pat_q[PAT_W-1];
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
          end else begin
            state_d   = S_GAP;
            gcnt_d    = gap_q;
            x_out_d   = GAP_FILL;
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
      end

      S_GAP: begin
        // gcnt_q counts filler cycles left including the one now on the wire.
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (gcnt_q == CNT_ONE) begin
          state_d   = S_SEND;
          idx_d     = IDX_MSB;
          x_out_d   = pat_q[PAT_W-1];
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end else begin
          gcnt_d    = gcnt_q - CNT_ONE;
          x_out_d   = GAP_FILL;
          x_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched transfer parameters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pat_q      <= '0;
      rem_q      <= '0;
      gap_q      <= '0;
      gcnt_q     <= '0;
      idx_q      <= '0;
      x_out_q    <= 1'b0;
      x_valid_q  <= 1'b0;
      last_bit_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      rem_q      <= rem_d;
      gap_q      <= gap_d;
      gcnt_q     <= gcnt_d;
      idx_q      <= idx_d;
      x_out_q    <= x_out_d;
      x_valid_q  <= x_valid_d;
      last_bit_q <= last_bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.x_out    = x_out_q;
  assign bus.x_valid  = x_valid_q;
  assign bus.last_bit = last_bit_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
